// File: rtl/ad9952_cfg_ctrl_pkg.sv
// Shared AD9952 register map, frame descriptor and instruction helper.
// Reused by the config sequencer and by future readback logic.
package ad9952_cfg_ctrl_pkg;

    localparam logic [4:0] ADDR_CFR1 = 5'h00;
    localparam logic [4:0] ADDR_CFR2 = 5'h01;
    localparam logic [4:0] ADDR_ASF  = 5'h02;
    localparam logic [4:0] ADDR_ARR  = 5'h03;
    localparam logic [4:0] ADDR_FTW0 = 5'h04;
    localparam logic [4:0] ADDR_POW0 = 5'h05;

    localparam logic [2:0] LEN_CFR1 = 3'd4;
    localparam logic [2:0] LEN_CFR2 = 3'd3;
    localparam logic [2:0] LEN_ASF  = 3'd2;
    localparam logic [2:0] LEN_ARR  = 3'd1;
    localparam logic [2:0] LEN_FTW0 = 3'd4;
    localparam logic [2:0] LEN_POW0 = 3'd2;

    // Bit 7 of the instruction byte selects read (1) or write (0).
    localparam int INSTR_RW_BIT = 7;

    typedef struct packed {
        logic [4:0]  addr;
        logic [2:0]  nbytes;
        logic [31:0] data;   // right-aligned register value
    } frame_t;

    function automatic logic [7:0] wr_instr(input logic [4:0] addr);
        logic [7:0] instr;
        instr               = {3'b000, addr};
        instr[INSTR_RW_BIT] = 1'b0;
        return instr;
    endfunction

endpackage

// File: rtl/ad9952_frame_ser.sv
// Frame serializer: on load emits the write instruction, then the register
// bytes MSB first, one per cycle with no gaps. last marks the final byte cycle.
module ad9952_frame_ser
    import ad9952_cfg_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       n_rst,
    input  logic       load,
    input  frame_t     frame,
    output logic [7:0] tx_data,
    output logic       tx_ena,
    output logic       last
);

    logic [31:0] sh_q, sh_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [7:0]  data_q, data_d;
    logic        ena_q, ena_d;

    assign tx_data = data_q;
    assign tx_ena  = ena_q;
    assign last    = ena_q && (cnt_q == 3'd0);

    always_comb begin
        sh_d   = sh_q;
        cnt_d  = cnt_q;
        data_d = data_q;
        ena_d  = ena_q;
        if (load) begin
            data_d = wr_instr(frame.addr);
            ena_d  = 1'b1;
            cnt_d  = frame.nbytes;
            // Left-align so the register's MSB byte always sits in [31:24].
            case (frame.nbytes)
                3'd1:    sh_d = {frame.data[7:0], 24'h0};
                3'd2:    sh_d = {frame.data[15:0], 16'h0};
                3'd3:    sh_d = {frame.data[23:0], 8'h0};
                default: sh_d = frame.data;
            endcase
        end else if (ena_q) begin
            if (cnt_q == 3'd0) begin
                ena_d = 1'b0;   // tx_data keeps the last byte
            end else begin
                data_d = sh_q[31:24];
                sh_d   = {sh_q[23:0], 8'h00};
                cnt_d  = cnt_q - 3'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sh_q   <= '0;
            cnt_q  <= '0;
            data_q <= '0;
            ena_q  <= 1'b0;
        end else begin
            sh_q   <= sh_d;
            cnt_q  <= cnt_d;
            data_q <= data_d;
            ena_q  <= ena_d;
        end
    end

endmodule

// File: rtl/ad9952_cfg_ctrl.sv
// AD9952 register sequencer: captures init/ftw/pow requests, arbitrates the SPI
// byte channel, and holds each frame until io_update confirms it (or times out).
module ad9952_cfg_ctrl
    import ad9952_cfg_ctrl_pkg::*;
#(
    parameter logic [31:0] CFR1_INIT   = 32'h0000_0000,
    parameter logic [23:0] CFR2_INIT   = 24'h00_0000,
    parameter logic [15:0] ASF_INIT    = 16'h0000,
    parameter logic [7:0]  ARR_INIT    = 8'h00,
    parameter int          TIMEOUT_CYC = 4096
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        init_req,
    input  logic        ftw_req,
    input  logic [31:0] ftw,
    input  logic        pow_req,
    input  logic [13:0] pow,
    input  logic        io_update,
    output logic [7:0]  tx_data,
    output logic        tx_ena,
    output logic        busy,
    output logic        init_done,
    output logic        err_to
);

    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEND = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;

    logic [1:0]    state_q, state_d;
    logic          init_pend_q, init_pend_d;
    logic          ftw_pend_q, ftw_pend_d;
    logic          pow_pend_q, pow_pend_d;
    logic [31:0]   ftw_val_q, ftw_val_d;
    logic [13:0]   pow_val_q, pow_val_d;
    logic          in_init_q, in_init_d;
    logic [1:0]    step_q, step_d;
    logic [CW-1:0] tmo_q, tmo_d;
    logic          upd_q, upd_d;
    logic          upd_edge_q, upd_edge_d;
    logic          busy_q, busy_d;
    logic          init_done_q, init_done_d;
    logic          err_q, err_d;

    logic   ser_load;
    frame_t ser_frame;
    logic   ser_last;

    function automatic frame_t init_frame(input logic [1:0] step);
        case (step)
            2'd0:    return '{addr: ADDR_CFR1, nbytes: LEN_CFR1, data: CFR1_INIT};
            2'd1:    return '{addr: ADDR_CFR2, nbytes: LEN_CFR2, data: {8'h00, CFR2_INIT}};
            2'd2:    return '{addr: ADDR_ASF,  nbytes: LEN_ASF,  data: {16'h0000, ASF_INIT}};
            default: return '{addr: ADDR_ARR,  nbytes: LEN_ARR,  data: {24'h00_0000, ARR_INIT}};
        endcase
    endfunction

    ad9952_frame_ser u_ser (
        .clk     (clk),
        .n_rst   (n_rst),
        .load    (ser_load),
        .frame   (ser_frame),
        .tx_data (tx_data),
        .tx_ena  (tx_ena),
        .last    (ser_last)
    );

    always_comb begin
        state_d     = state_q;
        init_pend_d = init_pend_q;
        ftw_pend_d  = ftw_pend_q;
        pow_pend_d  = pow_pend_q;
        ftw_val_d   = ftw_req ? ftw : ftw_val_q;
        pow_val_d   = pow_req ? pow : pow_val_q;
        in_init_d   = in_init_q;
        step_d      = step_q;
        tmo_d       = tmo_q;
        upd_d       = io_update;
        upd_edge_d  = io_update & ~upd_q;
        init_done_d = init_done_q;
        err_d       = err_q;
        ser_load    = 1'b0;
        ser_frame   = '0;

        case (state_q)
            ST_IDLE: begin
                if (init_pend_q) begin
                    init_pend_d = 1'b0;
                    in_init_d   = 1'b1;
                    step_d      = 2'd0;
                    ser_load    = 1'b1;
                    ser_frame   = init_frame(2'd0);
                    state_d     = ST_SEND;
                end else if (ftw_pend_q) begin
                    ftw_pend_d = 1'b0;
                    in_init_d  = 1'b0;
                    ser_load   = 1'b1;
                    ser_frame  = '{addr: ADDR_FTW0, nbytes: LEN_FTW0, data: ftw_val_q};
                    state_d    = ST_SEND;
                end else if (pow_pend_q) begin
                    pow_pend_d = 1'b0;
                    in_init_d  = 1'b0;
                    ser_load   = 1'b1;
                    ser_frame  = '{addr: ADDR_POW0, nbytes: LEN_POW0, data: {18'h0, pow_val_q}};
                    state_d    = ST_SEND;
                end
            end
            ST_SEND: begin
                if (ser_last) begin
                    state_d = ST_WAIT;
                    tmo_d   = '0;
                end
            end
            ST_WAIT: begin
                // io_update is checked before the timeout so a coincident edge wins.
                if (upd_edge_q) begin
                    if (in_init_q && step_q != 2'd3) begin
                        step_d    = step_q + 2'd1;
                        ser_load  = 1'b1;
                        ser_frame = init_frame(step_q + 2'd1);
                        state_d   = ST_SEND;
                    end else begin
                        if (in_init_q) init_done_d = 1'b1;
                        in_init_d = 1'b0;
                        state_d   = ST_IDLE;
                    end
                end else if (tmo_q == CW'(TIMEOUT_CYC - 1)) begin
                    err_d     = 1'b1;
                    in_init_d = 1'b0;
                    state_d   = ST_IDLE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // New requests override a launch-cycle clear so they are sent again later.
        if (init_req) init_pend_d = 1'b1;
        if (ftw_req)  ftw_pend_d  = 1'b1;
        if (pow_req)  pow_pend_d  = 1'b1;

        busy_d = (state_d != ST_IDLE) | init_pend_d | ftw_pend_d | pow_pend_d;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q     <= ST_IDLE;
            init_pend_q <= 1'b0;
            ftw_pend_q  <= 1'b0;
            pow_pend_q  <= 1'b0;
            ftw_val_q   <= '0;
            pow_val_q   <= '0;
            in_init_q   <= 1'b0;
            step_q      <= '0;
            tmo_q       <= '0;
            upd_q       <= 1'b0;
            upd_edge_q  <= 1'b0;
            busy_q      <= 1'b0;
            init_done_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            init_pend_q <= init_pend_d;
            ftw_pend_q  <= ftw_pend_d;
            pow_pend_q  <= pow_pend_d;
            ftw_val_q   <= ftw_val_d;
            pow_val_q   <= pow_val_d;
            in_init_q   <= in_init_d;
            step_q      <= step_d;
            tmo_q       <= tmo_d;
            upd_q       <= upd_d;
            upd_edge_q  <= upd_edge_d;
            busy_q      <= busy_d;
            init_done_q <= init_done_d;
            err_q       <= err_d;
        end
    end

    assign busy      = busy_q;
    assign init_done = init_done_q;
    assign err_to    = err_q;

endmodule

// File: tb/tb_ad9952_cfg_ctrl.sv
// Bench for ad9952_cfg_ctrl: collects emitted frames, answers with io_update
// pulses, and compares against frames built from the AD9952 register table.
module tb_ad9952_cfg_ctrl;

    localparam logic [31:0] CFR1 = 32'h0000_0202;
    localparam logic [23:0] CFR2 = 24'hA5_0F18;
    localparam logic [15:0] ASF  = 16'h3C81;
    localparam logic [7:0]  ARR  = 8'h7E;
    localparam int          TMO  = 16;

    logic        clk = 1'b0, n_rst = 1'b0;
    logic        init_req = 1'b0, ftw_req = 1'b0, pow_req = 1'b0, io_update = 1'b0;
    logic [31:0] ftw = '0;
    logic [13:0] pow = '0;
    logic [7:0]  tx_data;
    logic        tx_ena, busy, init_done, err_to;

    ad9952_cfg_ctrl #(
        .CFR1_INIT(CFR1), .CFR2_INIT(CFR2), .ASF_INIT(ASF), .ARR_INIT(ARR), .TIMEOUT_CYC(TMO)
    ) dut (
        .clk(clk), .n_rst(n_rst), .init_req(init_req), .ftw_req(ftw_req), .ftw(ftw),
        .pow_req(pow_req), .pow(pow), .io_update(io_update), .tx_data(tx_data),
        .tx_ena(tx_ena), .busy(busy), .init_done(init_done), .err_to(err_to)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_pass = 0;
    int cyc = 0, upd_cnt = 0, end_cyc = 0, cur_len = 0;
    bit auto_upd = 1'b1;
    logic [47:0] cur = '0;            // [47:40] length, bytes left-aligned below
    logic [47:0] got_q[$];
    int          start_cyc_q[$];
    int          upd_at_start_q[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Expected frame from the register table: address byte then value MSB first.
    function automatic logic [47:0] mk(input logic [7:0] addr, input int n, input logic [31:0] v);
        logic [47:0] f;
        f = '0;
        f[47:40] = 8'(n + 1);
        f[39:32] = addr;
        for (int i = 0; i < n; i++) f[31-8*i -: 8] = 8'(v >> (8 * (n - 1 - i)));
        return f;
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Frame collector
    initial forever begin
        @(negedge clk);
        if (tx_ena) begin
            if (cur_len == 0) begin
                start_cyc_q.push_back(cyc);
                upd_at_start_q.push_back(upd_cnt);
                cur = '0;
            end
            if (cur_len < 5) cur[39-8*cur_len -: 8] = tx_data;
            cur_len++;
        end else if (cur_len > 0) begin
            cur[47:40] = 8'(cur_len);
            got_q.push_back(cur);
            end_cyc = cyc;
            cur_len = 0;
        end
    end

    // DDS-side responder: io_update pulse a random few cycles after each frame
    initial forever begin
        @(negedge clk);
        if (tx_ena) begin
            while (tx_ena) @(negedge clk);
            if (auto_upd) begin
                repeat ($urandom_range(1, 5)) @(negedge clk);
                io_update = 1'b1;
                upd_cnt++;
                @(negedge clk);
                io_update = 1'b0;
            end
        end
    end

    task automatic clear_q();
        got_q.delete();
        start_cyc_q.delete();
        upd_at_start_q.delete();
    endtask

    task automatic wait_frames(input int n, input int budget);
        int k = 0;
        while (got_q.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk("frame_count", 64'(got_q.size()), 64'(n));
    endtask

    task automatic cmp_frame(input string tag, input logic [47:0] exp);
        logic [47:0] g = '0;
        if (got_q.size() > 0) g = got_q.pop_front();
        chk(tag, g, exp);
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        while (busy && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk("busy_clear", busy, 1'b0);
    endtask

    task automatic req(input bit f, input bit p, input logic [31:0] fv, input logic [13:0] pv);
        @(negedge clk);
        ftw_req = f; pow_req = p; ftw = fv; pow = pv;
        @(negedge clk);
        ftw_req = 1'b0; pow_req = 1'b0;
    endtask

    initial begin
        logic [31:0] fa, fb;
        logic [13:0] pv;
        int rc, u0, k, err_cyc, nb;

        repeat (3) @(negedge clk);
        chk("rst_tx_ena", tx_ena, 1'b0);
        chk("rst_tx_data", tx_data, 8'h00);
        chk("rst_busy", busy, 1'b0);
        chk("rst_init_done", init_done, 1'b0);
        chk("rst_err_to", err_to, 1'b0);
        n_rst = 1'b1;
        repeat (2) @(negedge clk);

        // Single FTW write with latency and busy tracking
        clear_q();
        u0 = upd_cnt;
        @(negedge clk);
        ftw_req = 1'b1; ftw = 32'h1234_5678; rc = cyc;
        @(negedge clk);
        ftw_req = 1'b0;
        chk("t1_busy", busy, 1'b1);
        wait_frames(1, 50);
        cmp_frame("t1_ftw", mk(8'h04, 4, 32'h1234_5678));
        chk("t1_latency", 64'((start_cyc_q.size() > 0) ? start_cyc_q[0] - rc : -1), 64'd2);
        wait_idle(50);
        chk("t1_upd_before_idle", 64'(upd_cnt - u0), 64'd1);
        chk("t1_no_init_done", init_done, 1'b0);

        // Init sequence, each frame gated by the previous io_update
        clear_q();
        u0 = upd_cnt;
        @(negedge clk); init_req = 1'b1;
        @(negedge clk); init_req = 1'b0;
        wait_frames(4, 400);
        for (int i = 0; i < 4; i++)
            chk("t2_gate", 64'((upd_at_start_q.size() > i) ? upd_at_start_q[i] - u0 : -1), 64'(i));
        cmp_frame("t2_cfr1", mk(8'h00, 4, CFR1));
        cmp_frame("t2_cfr2", mk(8'h01, 3, {8'h00, CFR2}));
        cmp_frame("t2_asf",  mk(8'h02, 2, {16'h0, ASF}));
        cmp_frame("t2_arr",  mk(8'h03, 1, {24'h0, ARR}));
        wait_idle(50);
        chk("t2_init_done", init_done, 1'b1);

        // Simultaneous FTW+POW: FTW wins, POW follows
        for (int it = 0; it < 3; it++) begin
            clear_q();
            fa = $urandom;
            pv = (it == 0) ? 14'h3FFF : 14'($urandom_range(0, 16383));
            req(1'b1, 1'b1, fa, pv);
            wait_frames(2, 100);
            cmp_frame("t3_ftw", mk(8'h04, 4, fa));
            cmp_frame("t3_pow", mk(8'h05, 2, {18'h0, pv}));
            wait_idle(50);
        end

        // Two FTW requests during init: only the last value is sent, once
        clear_q();
        fa = $urandom; fb = $urandom;
        @(negedge clk); init_req = 1'b1;
        @(negedge clk); init_req = 1'b0;
        wait_frames(1, 100);
        req(1'b1, 1'b0, fa, 14'h0);
        repeat (3) @(negedge clk);
        req(1'b1, 1'b0, fb, 14'h0);
        wait_frames(5, 600);
        cmp_frame("t4_cfr1", mk(8'h00, 4, CFR1));
        cmp_frame("t4_cfr2", mk(8'h01, 3, {8'h00, CFR2}));
        cmp_frame("t4_asf",  mk(8'h02, 2, {16'h0, ASF}));
        cmp_frame("t4_arr",  mk(8'h03, 1, {24'h0, ARR}));
        cmp_frame("t4_ftw_last", mk(8'h04, 4, fb));
        wait_idle(50);
        repeat (20) @(negedge clk);
        chk("t4_no_extra", 64'(got_q.size()), 64'd0);

        // Random single requests
        for (int it = 0; it < 6; it++) begin
            clear_q();
            fa = $urandom;
            pv = 14'($urandom_range(0, 16383));
            if ($urandom_range(0, 1) == 1) begin
                req(1'b1, 1'b0, fa, 14'h0);
                wait_frames(1, 50);
                cmp_frame("rnd_ftw", mk(8'h04, 4, fa));
            end else begin
                req(1'b0, 1'b1, 32'h0, pv);
                wait_frames(1, 50);
                cmp_frame("rnd_pow", mk(8'h05, 2, {18'h0, pv}));
            end
            wait_idle(50);
        end

        // io_update timeout, then recovery
        clear_q();
        auto_upd = 1'b0;
        fa = $urandom;
        req(1'b1, 1'b0, fa, 14'h0);
        wait_frames(1, 50);
        cmp_frame("t5_ftw", mk(8'h04, 4, fa));
        k = 0; err_cyc = -1;
        while (k < 60 && err_cyc < 0) begin
            if (err_to) err_cyc = cyc;
            else @(negedge clk);
            k++;
        end
        chk("t5_err_delay", 64'(err_cyc - end_cyc), 64'(TMO));
        chk("t5_busy_after_err", busy, 1'b0);
        auto_upd = 1'b1;
        pv = 14'($urandom_range(0, 16383));
        req(1'b0, 1'b1, 32'h0, pv);
        wait_frames(1, 50);
        cmp_frame("t5_pow", mk(8'h05, 2, {18'h0, pv}));
        wait_idle(50);
        chk("t5_err_sticky", err_to, 1'b1);

        // Reset mid-frame
        clear_q();
        auto_upd = 1'b0;
        req(1'b1, 1'b0, $urandom, 14'h0);
        nb = 0; k = 0;
        while (nb < 3 && k < 50) begin
            @(negedge clk);
            if (tx_ena) nb++;
            k++;
        end
        chk("t6_reached_byte3", 64'(nb), 64'd3);
        #1 n_rst = 1'b0;
        #1;
        chk("t6_tx_ena", tx_ena, 1'b0);
        chk("t6_busy", busy, 1'b0);
        chk("t6_init_done", init_done, 1'b0);
        chk("t6_err_to", err_to, 1'b0);
        repeat (3) @(negedge clk);
        clear_q();
        n_rst = 1'b1;
        repeat (15) @(negedge clk);
        chk("t6_no_resume", 64'(got_q.size()), 64'd0);
        auto_upd = 1'b1;

        clear_q();
        fa = $urandom;
        req(1'b1, 1'b0, fa, 14'h0);
        wait_frames(1, 50);
        cmp_frame("t6_recover", mk(8'h04, 4, fa));
        wait_idle(50);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
